// File: rtl/sbie_arith_pkg.sv
// Shared types and limits for the SBIE arithmetic blocks.
package sbie_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } sub_state_t;

  localparam int SBIE_MAX_WIDTH = 32;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bi, with borrow-out bo.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/sub4_serial_borrow.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, with a
// single borrow flop carried between bit positions.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Once asserted, out_valid holds d/bout stable until out_ready.
// in_ready depends combinationally on out_ready so a result can be retired
// and new operands accepted on the same edge.
module sub4_serial_borrow
  import sbie_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;

  logic diff_bit;
  logic brw_next;

  full_subtractor_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bi (brw),
    .d  (diff_bit),
    .bo (brw_next)
  );

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);

  // d and bout come straight from the shift register and borrow flop;
  // both are frozen while the FSM sits in DONE.
  assign d    = d_sh;
  assign bout = brw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      d_sh      <= '0;
      brw       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= {diff_bit, d_sh[WIDTH-1:1]};
          brw  <= brw_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_sh  <= a;
              b_sh  <= b;
              brw   <= bin;
              cnt   <= '0;
              state <= ST_SHIFT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub4_serial_borrow.sv
// Directed and exhaustive checks of sub4_serial_borrow with a result queue.
module tb_sub4_serial_borrow;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;

  logic rand_mode;
  logic fixed_ready;
  logic rnd_ready;

  logic [W:0] exp_q[$];
  int checks;
  int errors;

  sub4_serial_borrow #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_ready = rand_mode ? rnd_ready : fixed_ready;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic cv);
    return {1'b0, av} - (W+1)'(bv) - (W+1)'(cv);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present operands, wait for acceptance, record the expected result
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    int n;
    a        = av;
    b        = bv;
    bin      = cv;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom_range(0, 15));
    b        = W'($urandom_range(0, 15));
    bin      = 1'($urandom_range(0, 1));
    exp_q.push_back(model(av, bv, cv));
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: compare on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("result_without_request", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result_bout_d", 32'({bout, d}), 32'(e));
      end
    end
  end

  initial begin
    int lat;
    int n;
    logic [W:0] hold_exp;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    bin         = 1'b0;
    rand_mode   = 1'b0;
    fixed_ready = 1'b1;

    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_d", 32'(d), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic subtraction and latency from the accept edge
    send(4'h9, 4'h3, 1'b0);
    lat = 1;
    while (lat < 50) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency_edges", 32'(lat), 32'(W + 1));
    drain(50);

    // underflow and edge operands
    send(4'h3, 4'h9, 1'b0);
    send(4'h0, 4'h0, 1'b1);
    send(4'hF, 4'hF, 1'b1);
    send(4'hF, 4'h0, 1'b0);
    drain(100);

    // asynchronous reset in the middle of a shift
    send(4'h5, 4'h2, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_d", 32'(d), 32'd0);
    check("midreset_bout", 32'(bout), 32'd0);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("no_stale_result", 32'(out_valid), 32'd0);

    // backpressure: DONE holds while a new operand set waits
    fixed_ready = 1'b0;
    send(4'hC, 4'h5, 1'b1);
    hold_exp = model(4'hC, 4'h5, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    a        = 4'h7;
    b        = 4'h2;
    bin      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_bout_d", 32'({bout, d}), 32'(hold_exp));
      @(posedge clk);
      #1;
    end
    fixed_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(model(4'h7, 4'h2, 1'b0));
    drain(50);

    // exhaustive operands with random output stalls
    rand_mode = 1'b1;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          send(W'(ai), W'(bi), 1'(ci));
        end
      end
    end
    drain(500);
    rand_mode = 1'b0;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
